multdiv_unit: RTL
=================

// Module: multdiv_unit
// PURPOSE
//  Iterative signed 32-bit multiply/divide responder serving the pipeline's execute stage.
//  The X stage issues a one-cycle ctrl_MULT or ctrl_DIV pulse with operands. The pipeline stalls until
//  data_resultRDY. It then writes data_result into the M latch, and data_exception into the overflow path.
//  One operation is in flight at a time; it is owned entirely by this block.
// PARAMETERS
//  WIDTH  32  operand/result width. Only 32 is supported; the iteration counter is sized from it.
// PORTS
//  clock           in   1   master clock, all state updates on rising edge
//  reset           in   1   asynchronous, active-low reset
//  ctrl_MULT       in   1   start-multiply pulse, operands sampled same edge
//  ctrl_DIV        in   1   start-divide pulse, operands sampled same edge
//  data_operandA   in   32  multiplicand / dividend (two's complement)
//  data_operandB   in   32  multiplier / divisor (two's complement)
//  data_result     out  32  product low word / quotient
//  data_exception  out  1   overflow or divide-by-zero flag
//  data_resultRDY  out  1   one-cycle pulse: result and exception valid
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0.
//  - FSM states and transitions:
//    IDLE -> MULT on ctrl_MULT.
//    IDLE -> DIV on ctrl_DIV.
//    MULT/DIV -> DONE when the iteration count is reached.
//    DONE -> IDLE after one cycle.
//  - Start edge E0: latch A, B, and op type; clear the counter. If both ctrl_MULT and ctrl_DIV are high, MULT wins.
//  - Restart: a ctrl pulse in any state (incl. MULT/DIV/DONE) aborts the current op.
//    The block restarts at E0 with the new operands; no RDY is issued for the aborted op.
//  - MULT (radix-2, default): shift-add on a 64-bit product register, 32 iterations at edges E1..E32.
//    The correction step for the signed multiplier MSB is included.
//  - DIV: restoring division on |A|, |B|, 32 iterations at edges E1..E32.
//    Quotient sign = sign(A) XOR sign(B), truncated toward zero. The remainder is discarded.
//  - Completion: DONE is entered at edge E33.
//    data_resultRDY=1 for exactly the cycle after E33.
//  - data_result/data_exception update at the same edge as RDY rises.
//    They hold until the next E0 or reset, and are not cleared when RDY falls.
//  - data_resultRDY is never asserted in IDLE, MULT, or DIV.
//  - MULT exception rule:
//    exception=1 iff the 64-bit product != sign-extension of its low 32 bits.
//    result = low 32 bits regardless.
//  - DIV by zero (B==0): exception=1, result=0. Full latency is still observed; no early exit.
//  - DIV overflow (A=0x80000000, B=0xFFFFFFFF): exception=1, result=0x80000000.
//  - Operand inputs are ignored except at E0, so the source may change them freely mid-operation.
//  - Counter width is clog2(WIDTH)+1.
//    The counter saturates in DONE and never wraps during an operation.
// CONFIGURATION
//  BOOTH_RADIX4_EN defined:
//    MULT uses radix-4 Booth recoding (digits -2..+2) over 16 iterations at E1..E16.
//    DONE is entered at E17; RDY is high the cycle after E17.
//    DIV latency is unchanged (E33). The exception and result rules are identical.
//  BOOTH_RADIX4_EN undefined: radix-2 as above, and MULT latency is E33.
// TESTING
//  1. Reset low, then high; pulse MULT A=7, B=-3 (0xFFFFFFFD).
//     -> RDY only after E33 (E17 with macro), result=0xFFFFFFEB, exc=0.
//  2. MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exc=1.
//     Also MULT A=0x80000000, B=1 -> result=0x80000000, exc=0.
//  3. DIV A=-100, B=7 -> result=0xFFFFFFF2 (-14), exc=0, RDY after E33.
//     Also DIV 100/-7 -> 0xFFFFFFF2.
//  4. DIV A=5, B=0 -> result=0, exc=1 after E33.
//     Also DIV A=0x80000000, B=-1 -> result=0x80000000, exc=1.
//  5. Pulse DIV 50/5, then pulse MULT 6*7 at E10.
//     -> no RDY for the divide; RDY 33 edges after the MULT pulse with result=42, exc=0.
//  6. Drive reset low at E20 of MULT 3*3.
//     -> outputs zero immediately and no RDY appears.
//     A fresh MULT 3*3 after release -> result=9.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide responder for the execute stage; one op in flight, RDY is a one-cycle pulse.
// Optional BOOTH_RADIX4_EN: radix-4 Booth multiply (16 iterations) instead of radix-2 shift-add (32 iterations).
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int W  = WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;
`ifdef BOOTH_RADIX4_EN
   localparam int MULT_ITERS = WIDTH / 2;
   localparam int AW         = WIDTH + 2;
`else
   localparam int MULT_ITERS = WIDTH;
   localparam int AW         = WIDTH;
`endif
   localparam logic [CW-1:0] MULT_LAST = CW'(MULT_ITERS);
   localparam logic [CW-1:0] DIV_LAST  = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] iter_last;
   logic [AW-1:0] acc, acc_nxt;
   logic [W-1:0]  lo, lo_nxt;
   logic [W-1:0]  mcand;
   logic          div_neg, div_zero, div_ovf;
   logic          start;
   logic          iterate;
   logic [W:0]    div_shift, div_diff;
`ifdef BOOTH_RADIX4_EN
   logic          prev, prev_nxt;
   logic [AW-1:0] a_ext, booth_add, mul_sum;
`else
   localparam logic [CW-1:0] MULT_PEN = CW'(MULT_ITERS - 1);
   logic [W:0]    mul_add, mul_sum;
`endif

   assign start          = ctrl_MULT | ctrl_DIV;
   assign iter_last      = (state == S_MULT) ? MULT_LAST : DIV_LAST;
   assign iterate        = ((state == S_MULT) || (state == S_DIV)) && (cnt != iter_last);
   assign data_resultRDY = (state == S_DONE);

   // A new pulse always wins, in any state, so an in-flight op is silently abandoned.
   always_comb begin
      state_nxt = state;
      if (ctrl_MULT) begin
         state_nxt = S_MULT;
      end else if (ctrl_DIV) begin
         state_nxt = S_DIV;
      end else begin
         case (state)
            S_MULT:  if (cnt == MULT_LAST) state_nxt = S_DONE;
            S_DIV:   if (cnt == DIV_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      acc_nxt = acc;
      lo_nxt  = lo;
`ifdef BOOTH_RADIX4_EN
      prev_nxt  = prev;
      a_ext     = {{2{mcand[W-1]}}, mcand};
      booth_add = '0;
      case ({lo[1], lo[0], prev})
         3'b001, 3'b010: booth_add = a_ext;
         3'b011:         booth_add = a_ext << 1;
         3'b100:         booth_add = -(a_ext << 1);
         3'b101, 3'b110: booth_add = -a_ext;
         default:        booth_add = '0;
      endcase
      mul_sum = acc + booth_add;
`else
      // Multiplier bit 31 carries weight -2^31, so the final partial product is subtracted.
      mul_add = lo[0] ? {mcand[W-1], mcand} : '0;
      mul_sum = (cnt == MULT_PEN) ? ({acc[W-1], acc} - mul_add) : ({acc[W-1], acc} + mul_add);
`endif
      div_shift = {acc[W-1:0], lo[W-1]};
      div_diff  = div_shift - {1'b0, mcand};
      if (state == S_MULT) begin
`ifdef BOOTH_RADIX4_EN
         acc_nxt  = {{2{mul_sum[AW-1]}}, mul_sum[AW-1:2]};
         lo_nxt   = {mul_sum[1:0], lo[W-1:2]};
         prev_nxt = lo[1];
`else
         acc_nxt = mul_sum[W:1];
         lo_nxt  = {mul_sum[0], lo[W-1:1]};
`endif
      end else begin
         acc_nxt = div_diff[W] ? AW'(div_shift[W-1:0]) : AW'(div_diff[W-1:0]);
         lo_nxt  = {lo[W-2:0], ~div_diff[W]};
      end
   end

   // acc/lo hold the running product (high/low) or remainder/quotient, depending on op.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt            <= '0;
         acc            <= '0;
         lo             <= '0;
         mcand          <= '0;
         div_neg        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
`ifdef BOOTH_RADIX4_EN
         prev           <= 1'b0;
`endif
      end else if (start) begin
         cnt            <= '0;
         acc            <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
`ifdef BOOTH_RADIX4_EN
         prev           <= 1'b0;
`endif
         if (ctrl_MULT) begin
            lo       <= data_operandB;
            mcand    <= data_operandA;
            div_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
         end else begin
            lo       <= data_operandA[W-1] ? -data_operandA : data_operandA;
            mcand    <= data_operandB[W-1] ? -data_operandB : data_operandB;
            div_neg  <= data_operandA[W-1] ^ data_operandB[W-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(W-1){1'b0}}}) && (data_operandB == '1);
         end
      end else if (iterate) begin
         cnt <= cnt + 1'b1;
         acc <= acc_nxt;
         lo  <= lo_nxt;
`ifdef BOOTH_RADIX4_EN
         prev <= prev_nxt;
`endif
      end else if (state == S_MULT) begin
         data_result    <= lo;
         data_exception <= (acc[W-1:0] != {W{lo[W-1]}});
      end else if (state == S_DIV) begin
         data_result    <= div_zero ? '0 : (div_neg ? -lo : lo);
         data_exception <= div_zero | div_ovf;
      end
   end

endmodule
